// File: rtl/fetch_queue_unit.sv
// In-order instruction fetch queue between instruction memory and decode, with redirect-aware response dropping.
// Optional build macro FETCH_STALL_CNT_EN adds the stall_cnt front-end bubble counter output.
module fetch_queue_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrF,
  output logic        ValidF
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] fill_ptr_q;
  logic [CW-1:0] n_alloc_q;
  logic [CW-1:0] n_fill_q;
  logic [CW-1:0] n_pend;
  logic [31:0]   fpc_q;
  logic [31:0]   drop_q;

  logic          issue;
  logic          drop_resp;
  logic          resp_taken;
  logic          fill;
  logic          pop;
  logic          consumed;

  assign n_pend     = n_alloc_q - n_fill_q;
  assign ValidF     = (n_fill_q != '0);
  assign imem_req   = !rst && !PCSrcE && (n_alloc_q < FULL);
  assign imem_addr  = fpc_q;
  assign issue      = imem_req && imem_gnt;
  assign drop_resp  = imem_rvalid && (drop_q != '0);
  assign resp_taken = imem_rvalid && (drop_q == '0) && (n_pend != '0);
  assign fill       = resp_taken && !PCSrcE;
  assign pop        = ValidF && !StallF && !PCSrcE;
  assign consumed   = drop_resp || resp_taken;

  always_comb begin
    PCF      = '0;
    PCPlus4F = '0;
    InstrF   = NOP;
    if (ValidF) begin
      PCF      = pc_mem[rd_ptr_q];
      PCPlus4F = pc_mem[rd_ptr_q] + 32'd4;
      InstrF   = data_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      n_alloc_q  <= '0;
      n_fill_q   <= '0;
      drop_q     <= '0;
      fpc_q      <= RESET_PC & ~32'h3;
    end else if (PCSrcE) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      n_alloc_q  <= '0;
      n_fill_q   <= '0;
      fpc_q      <= PCTargetE & ~32'h3;
      // A response arriving this cycle retires one outstanding slot, whichever bucket it came from.
      drop_q     <= drop_q + 32'(n_pend) - {31'b0, consumed};
    end else begin
      if (issue) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        fpc_q    <= fpc_q + 32'd4;
      end
      if (fill) fill_ptr_q <= fill_ptr_q + PW'(1);
      if (pop)  rd_ptr_q   <= rd_ptr_q + PW'(1);
      n_alloc_q <= n_alloc_q + CW'(issue) - CW'(pop);
      n_fill_q  <= n_fill_q + CW'(fill) - CW'(pop);
      if (drop_resp) drop_q <= drop_q - 32'd1;
    end
  end

  // Entry payload needs no reset: occupancy counts gate every read.
  always_ff @(posedge clk) begin
    if (issue) pc_mem[wr_ptr_q]     <= fpc_q;
    if (fill)  data_mem[fill_ptr_q] <= imem_rdata;
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!ValidF && !StallF && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
